// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first.
// A single full-subtractor cell and a borrow flop are iterated over WIDTH
// cycles. Operands are taken on a valid/ready handshake, and the result is
// held under valid/ready until the consumer accepts it.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;

    // Full-subtractor cell outputs for the current bit
    logic             diff_bit;
    logic             br_next;

    // State and datapath registers; reset clears everything and wins over all inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
        end
    end

    // Next-state logic: accept in IDLE, one bit per cycle in RUN, hold in DONE
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        d_d      = d_q;
        bout_d   = bout_q;
        diff_bit = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
        br_next  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Difference bits enter at the top so bit 0 ends up at the LSB
                res_d  = {diff_bit, res_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    d_d     = {diff_bit, res_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == DONE);
    assign D         = d_q;
    assign Bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed cases, backpressure, reset
// mid-operation, operand isolation, exhaustive sweep and random traffic,
// all checked against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int WIDTH = 4;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .D        (D),
        .Bout     (Bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned ref_diff(input int unsigned x, input int unsigned y);
        return (x - y) & MASK;
    endfunction

    function automatic int unsigned ref_borrow(input int unsigned x, input int unsigned y);
        return (x < y) ? 1 : 0;
    endfunction

    // One full transaction from IDLE: accept, latency check, optional stall, drain.
    // scramble: change a/b after accept. stall: cycles of out_ready=0 in DONE,
    // during which a second operand (a=1,b=2) is offered and must be ignored.
    task automatic run_op(input int unsigned x, input int unsigned y,
                          input bit scramble, input int stall, input bit check_lat);
        int n;
        check("accept_ready", in_ready, 1);
        a         = WIDTH'(x);
        b         = WIDTH'(y);
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        if (scramble) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
        end
        n = 0;
        while (!out_valid && n < 3 * WIDTH) begin
            if (scramble) begin
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
            end
            tick();
            n++;
        end
        if (!out_valid) begin
            check("timeout_out_valid", 0, 1);
            return;
        end
        if (check_lat) check("latency", n, WIDTH);
        check("D", D, ref_diff(x, y));
        check("Bout", Bout, ref_borrow(x, y));
        for (int s = 0; s < stall; s++) begin
            a        = 4'd1;
            b        = 4'd2;
            in_valid = 1'b1;
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_D", D, ref_diff(x, y));
            check("stall_Bout", Bout, ref_borrow(x, y));
            check("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("drain_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 1);
        check("hold_D", D, ref_diff(x, y));
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        #1;
        check("rst_in_ready", in_ready, 0);
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_D", D, 0);
        check("rst_Bout", Bout, 0);
        check("rst_in_ready_edge", in_ready, 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);

        // Directed cases, including borrow-propagation corners
        run_op(9, 3, 0, 0, 1);
        run_op(3, 9, 0, 0, 1);
        run_op(0, 15, 0, 0, 1);
        run_op(0, 1, 0, 0, 1);
        run_op(15, 15, 0, 0, 1);
        run_op(15, 0, 0, 0, 1);
        run_op(8, 8, 0, 0, 1);

        // Backpressure; the a=1,b=2 offered during the stall must be ignored
        run_op(12, 5, 0, 6, 1);
        check("no_stray_accept", out_valid, 0);
        run_op(1, 2, 0, 0, 1);

        // Reset mid-RUN abandons the operation
        a        = 4'd6;
        b        = 4'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrun_rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check("midrun_out_valid", out_valid, 0);
        check("midrun_D", D, 0);
        check("midrun_Bout", Bout, 0);
        check("midrun_in_ready", in_ready, 1);
        n = 0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            tick();
            if (out_valid) n++;
        end
        check("midrun_no_result", n, 0);
        run_op(6, 2, 0, 0, 1);

        // Reset mid-DONE drops the pending result
        out_ready = 1'b0;
        a         = 4'd13;
        b         = 4'd2;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < WIDTH; i++) tick();
        check("done_before_rst", out_valid, 1);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("middone_out_valid", out_valid, 0);
        check("middone_D", D, 0);

        // Operand isolation
        a        = 4'd10;
        b        = 4'd4;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 4'd0;
        b        = 4'd15;
        n = 0;
        while (!out_valid && n < 3 * WIDTH) begin
            tick();
            n++;
        end
        check("iso_latency", n, WIDTH);
        check("iso_D", D, 6);
        check("iso_Bout", Bout, 0);
        tick();

        // Exhaustive sweep
        for (int x = 0; x <= MASK; x++)
            for (int y = 0; y <= MASK; y++)
                run_op(x, y, 0, 0, 0);

        // Random traffic with scrambled operands and random stalls
        for (int k = 0; k < 60; k++)
            run_op($urandom_range(MASK, 0), $urandom_range(MASK, 0), 1,
                   $urandom_range(3, 0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute time guard so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor, LSB first: accepts two WIDTH-bit operands and produces D = (a - b) mod 2^WIDTH plus a borrow-out flag.
- Uses one full-subtractor cell and a borrow flip-flop, iterated over WIDTH cycles, instead of a ripple chain.
- Valid/ready handshakes on both the operand and result sides let it sit between a register stage and a consumer that can stall.

Parameters:
WIDTH, 4, operand/result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operands a/b presented
in_ready  output  1  block can accept operands (IDLE state)
a  input  WIDTH  minuend, sampled only on input handshake
b  input  WIDTH  subtrahend, sampled only on input handshake
out_valid  output  1  D/Bout hold a completed result
out_ready  input  1  consumer accepts result
D  output  WIDTH  difference (a - b) mod 2^WIDTH
Bout  output  1  final borrow; 1 iff a < b (unsigned)

Behaviour:
- Reset (rst high at a rising edge):
  - state -> IDLE; D = 0, Bout = 0, out_valid = 0.
  - Internal shift registers, borrow flop and bit counter cleared.
  - in_ready = 0 while rst is high, 1 in IDLE otherwise.
  - rst overrides every other input in the same cycle.
- States: IDLE, RUN, DONE. in_ready = (state == IDLE) & ~rst; out_valid = (state == DONE), registered.
- IDLE:
  - On in_valid & in_ready at edge T: latch a, b into internal shift registers; borrow flop = 0; count = 0; -> RUN.
  - Otherwise stay in IDLE.
- RUN, one bit per edge, bit i = count:
  - d_i = a_i ^ b_i ^ br.
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d_i is shifted into the internal result register; operand registers shift right; count increments.
  - On the edge that processes bit WIDTH-1: D <= full result, Bout <= br_next; -> DONE.
- Latency: out_valid is first seen high after edge T+WIDTH, i.e. WIDTH cycles after the accepting edge.
- DONE:
  - out_valid = 1; D and Bout stable.
  - On out_ready high at an edge: -> IDLE; out_valid drops on that edge.
  - out_ready may be held low indefinitely; all outputs hold.
- D and Bout change only on entry to DONE, or on reset. Between results they hold the last value and are meaningful only when out_valid = 1.
- Changes on a/b after the accepting edge have no effect on the current result.
- in_valid is ignored in RUN and DONE; no operand is lost because in_ready = 0 there.
- A result accepted at edge E allows a new operand accept at edge E+1 at the earliest. Peak throughput is one operation per WIDTH+2 cycles.
- Reset mid-RUN or mid-DONE: the operation is abandoned, no out_valid is produced for it, and the block returns to IDLE.
- Wrap-around: a - b < 0 gives the two's-complement residue with Bout = 1 (e.g. 0 - 1 -> D = 2^WIDTH - 1, Bout = 1).

Test Plan:
- WIDTH=4, a=9, b=3, in_valid pulse, out_ready=1 -> out_valid high exactly 4 cycles after accept with D=6, Bout=0; in_ready high again the cycle after out_valid falls.
- a=3, b=9 -> D=10, Bout=1. a=0, b=15 -> D=1, Bout=1. a=0, b=1 -> D=15, Bout=1.
- a=15, b=15 -> D=0, Bout=0. a=15, b=0 -> D=15, Bout=0. a=8, b=8 -> D=0, Bout=0 (borrow propagation cases).
- Backpressure, a=12, b=5:
  - Hold out_ready=0 for 6 cycles after out_valid rises -> out_valid, D=7, Bout=0 held constant; in_ready stays 0.
  - Drive in_valid with a=1, b=2 during the stall -> ignored.
  - Raise out_ready -> IDLE next cycle; then the a=1, b=2 operation gives D=15, Bout=1.
- Reset mid-RUN: accept a=6, b=2; assert rst for one cycle after 2 RUN edges -> out_valid never rises for that operation, D=0, Bout=0, in_ready=1 the cycle after rst drops. A following a=6, b=2 gives D=4, Bout=0.
- Operand isolation: accept a=10, b=4, then drive a=0, b=15 during RUN -> result D=6, Bout=0. Exhaustive 256-pair sweep against a reference model (a-b)&15 / (a<b) passes.
